clk_timebase: RTL and testbench

- Shared timebase block for the position subsystem.
- A 32-bit cycle counter drives two compare engines:
  - a programmable square-wave frame clock (clk_frame);
  - a programmable periodic single-cycle interrupt pulse (int_o).
- Host logic sets the frame half-period and the interrupt interval in counter ticks, and gates each function independently.

---
 rtl/clk_timebase_if.sv | 25 ++
 rtl/clk_timebase.sv | 75 +++++++
 tb/tb_clk_timebase.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/clk_timebase_if.sv
// Host-side bundle for clk_timebase: counter control, both compare limits/enables,
// and the registered counter, frame clock and interrupt outputs.
interface clk_timebase_if #(
  parameter int CNT_W = 32
);
  logic             cnt_en;
  logic             cnt_clr;
  logic [CNT_W-1:0] count;
  logic             gen_en;
  logic [CNT_W-1:0] gen_limit;
  logic             clk_frame;
  logic             int_en;
  logic [CNT_W-1:0] int_limit;
  logic             int_o;

  modport master (
    output cnt_en, cnt_clr, gen_en, gen_limit, int_en, int_limit,
    input  count, clk_frame, int_o
  );

  modport slave (
    input  cnt_en, cnt_clr, gen_en, gen_limit, int_en, int_limit,
    output count, clk_frame, int_o
  );
endinterface

// File: rtl/clk_timebase.sv
// Shared timebase: free-running cycle counter feeding two equality-compare engines,
// a square-wave frame clock and a periodic single-cycle interrupt pulse.
module clk_timebase #(
  parameter int CNT_W = 32
) (
  input logic           clk,
  input logic           rst,
  clk_timebase_if.slave host
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] gen_target_q, gen_target_d;
  logic [CNT_W-1:0] int_target_q, int_target_d;
  logic             clk_frame_q, clk_frame_d;
  logic             int_o_q, int_o_d;
  logic             genMatch, intMatch;

  // Matches compare against the pre-increment count, so events appear one clk later.
  assign genMatch = (host.gen_limit != '0) && (count_q == gen_target_q);
  assign intMatch = (host.int_limit != '0) && (count_q == int_target_q);

  always_comb begin
    count_d = count_q;
    if (host.cnt_clr) begin
      count_d = '0;
    end else if (host.cnt_en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_comb begin
    gen_target_d = gen_target_q;
    clk_frame_d  = clk_frame_q;
    if (!host.gen_en) begin
      clk_frame_d  = 1'b0;
      gen_target_d = count_q + host.gen_limit;
    end else if (genMatch) begin
      clk_frame_d  = ~clk_frame_q;
      gen_target_d = gen_target_q + host.gen_limit;
    end
  end

  always_comb begin
    int_target_d = int_target_q;
    int_o_d      = 1'b0;
    if (!host.int_en) begin
      int_target_d = count_q + host.int_limit;
    end else if (intMatch) begin
      int_o_d      = 1'b1;
      int_target_d = int_target_q + host.int_limit;
    end
  end

  // Reset loads the targets straight from the limits so a counter starting at 0 fires at limit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q      <= '0;
      clk_frame_q  <= 1'b0;
      int_o_q      <= 1'b0;
      gen_target_q <= host.gen_limit;
      int_target_q <= host.int_limit;
    end else begin
      count_q      <= count_d;
      clk_frame_q  <= clk_frame_d;
      int_o_q      <= int_o_d;
      gen_target_q <= gen_target_d;
      int_target_q <= int_target_d;
    end
  end

  assign host.count     = count_q;
  assign host.clk_frame = clk_frame_q;
  assign host.int_o     = int_o_q;

endmodule

// File: tb/tb_clk_timebase.sv
// Bench for clk_timebase: directed plan on a 32-bit instance, wrap and random
// stimulus on an 8-bit instance, all checked against a rule-level model.
module tb_clk_timebase;

  logic clk = 1'b0;
  logic rstA, rstB;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  clk_timebase_if #(.CNT_W(32)) bus32 ();
  clk_timebase_if #(.CNT_W(8))  bus8 ();

  clk_timebase #(.CNT_W(32)) dut32 (.clk(clk), .rst(rstA), .host(bus32));
  clk_timebase #(.CNT_W(8))  dut8  (.clk(clk), .rst(rstB), .host(bus8));

  always #5 clk = ~clk;

  // Model state, index 0 = 32-bit instance, 1 = 8-bit instance.
  longint unsigned mCount[2], mGenT[2], mIntT[2], mMod[2];
  bit              mFrame[2], mInt[2];

  task automatic checkOutput(input string tag, input longint unsigned obs,
                             input longint unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic void modelStep(input int k, input bit rstn, input bit en,
                                    input bit clr, input bit ge, input longint unsigned gl,
                                    input bit ie, input longint unsigned il);
    longint unsigned c;
    c = mCount[k];
    if (!rstn) begin
      mCount[k] = 0; mFrame[k] = 0; mInt[k] = 0;
      mGenT[k]  = gl; mIntT[k] = il;
      return;
    end
    mCount[k] = clr ? 0 : (en ? (c + 1) % mMod[k] : c);
    if (!ge) begin
      mFrame[k] = 0;
      mGenT[k]  = (c + gl) % mMod[k];
    end else if (gl != 0 && c == mGenT[k]) begin
      mFrame[k] = !mFrame[k];
      mGenT[k]  = (mGenT[k] + gl) % mMod[k];
    end
    if (!ie) begin
      mInt[k]  = 0;
      mIntT[k] = (c + il) % mMod[k];
    end else if (il != 0 && c == mIntT[k]) begin
      mInt[k]  = 1;
      mIntT[k] = (mIntT[k] + il) % mMod[k];
    end else begin
      mInt[k] = 0;
    end
  endfunction

  // Inputs are set mid-cycle; this advances one edge, updates the model and checks both DUTs.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep(0, rstA, bus32.cnt_en, bus32.cnt_clr, bus32.gen_en, bus32.gen_limit,
              bus32.int_en, bus32.int_limit);
    modelStep(1, rstB, bus8.cnt_en, bus8.cnt_clr, bus8.gen_en, bus8.gen_limit,
              bus8.int_en, bus8.int_limit);
    #1;
    cyc++;
    checkOutput("count32", bus32.count, mCount[0]);
    checkOutput("frame32", bus32.clk_frame, mFrame[0]);
    checkOutput("int32", bus32.int_o, mInt[0]);
    checkOutput("count8", bus8.count, mCount[1]);
    checkOutput("frame8", bus8.clk_frame, mFrame[1]);
    checkOutput("int8", bus8.int_o, mInt[1]);
  endtask

  initial begin
    int lastPulse, lastToggle;
    bit prevFrame;
    mMod[0] = 64'h1_0000_0000;
    mMod[1] = 64'h100;
    mCount  = '{0, 0}; mGenT = '{0, 0}; mIntT = '{0, 0};
    mFrame  = '{0, 0}; mInt = '{0, 0};

    rstA = 1'b0; rstB = 1'b0;
    bus32.cnt_en = 1'b1; bus32.cnt_clr = 1'b0;
    bus32.gen_en = 1'b1; bus32.gen_limit = 32'd5;
    bus32.int_en = 1'b1; bus32.int_limit = 32'd4;
    bus8.cnt_en = 1'b1; bus8.cnt_clr = 1'b0;
    bus8.gen_en = 1'b1; bus8.gen_limit = 8'd5;
    bus8.int_en = 1'b1; bus8.int_limit = 8'd4;
    #2;
    applyStimulus();
    applyStimulus();
    checkOutput("resetCount", bus32.count, 0);
    checkOutput("resetFrame", bus32.clk_frame, 0);
    checkOutput("resetInt", bus32.int_o, 0);

    // Free-running count with frame half-period 5 and interrupt interval 4.
    rstA = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      applyStimulus();
      checkOutput("runCount", bus32.count, n);
      checkOutput("runFrame", bus32.clk_frame, ((n - 1) / 5) % 2);
      checkOutput("runInt", bus32.int_o, (n > 1 && (n - 1) % 4 == 0) ? 1 : 0);
    end

    bus32.cnt_en = 1'b0;
    repeat (3) begin
      applyStimulus();
      checkOutput("stallCount", bus32.count, 20);
    end
    bus32.cnt_en = 1'b1; bus32.cnt_clr = 1'b1;
    applyStimulus();
    checkOutput("clearCount", bus32.count, 0);
    bus32.cnt_clr = 1'b0;

    // Disabled frame clock reloads from the live count; re-enable after count=100.
    bus32.gen_en = 1'b0;
    repeat (100) begin
      applyStimulus();
      checkOutput("disabledFrame", bus32.clk_frame, 0);
    end
    checkOutput("count100", bus32.count, 100);
    bus32.gen_limit = 32'd3;
    applyStimulus();
    bus32.gen_en = 1'b1;
    for (int n = 102; n <= 108; n++) begin
      applyStimulus();
      checkOutput("reloadFrame", bus32.clk_frame, (n >= 104 && n <= 106) ? 1 : 0);
    end

    // Zero limits: no toggles and no pulses, then a mid-run reset.
    bus32.gen_limit = '0; bus32.int_limit = '0;
    prevFrame = bus32.clk_frame;
    repeat (20) begin
      applyStimulus();
      checkOutput("zeroFrame", bus32.clk_frame, prevFrame);
      checkOutput("zeroInt", bus32.int_o, 0);
    end
    bus32.gen_limit = 32'd2; bus32.int_limit = 32'd1;
    repeat (7) applyStimulus();
    rstA = 1'b0;
    applyStimulus();
    checkOutput("midResetCount", bus32.count, 0);
    checkOutput("midResetFrame", bus32.clk_frame, 0);
    checkOutput("midResetInt", bus32.int_o, 0);
    rstA = 1'b1;

    // 8-bit instance runs across several wraps; spacing must stay fixed.
    rstB = 1'b1;
    lastPulse = -1; lastToggle = -1;
    prevFrame = bus8.clk_frame;
    repeat (700) begin
      applyStimulus();
      if (bus8.int_o) begin
        if (lastPulse >= 0) checkOutput("wrapIntSpacing", cyc - lastPulse, 4);
        lastPulse = cyc;
      end
      if (bus8.clk_frame != prevFrame) begin
        if (lastToggle >= 0) checkOutput("wrapFrameSpacing", cyc - lastToggle, 5);
        lastToggle = cyc;
        prevFrame  = bus8.clk_frame;
      end
    end

    // Random traffic on both instances against the model.
    repeat (3000) begin
      rstA = ($urandom_range(0, 99) != 0);
      rstB = ($urandom_range(0, 63) != 0);
      bus32.cnt_en  = ($urandom_range(0, 7) != 0);
      bus32.cnt_clr = ($urandom_range(0, 40) == 0);
      bus32.gen_en  = ($urandom_range(0, 15) != 0);
      bus32.int_en  = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 49) == 0) bus32.gen_limit = $urandom_range(0, 12);
      if ($urandom_range(0, 49) == 0) bus32.int_limit = $urandom_range(0, 12);
      bus8.cnt_en  = ($urandom_range(0, 7) != 0);
      bus8.cnt_clr = ($urandom_range(0, 31) == 0);
      bus8.gen_en  = ($urandom_range(0, 15) != 0);
      bus8.int_en  = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 49) == 0) bus8.gen_limit = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 29) == 0) bus8.int_limit = 8'($urandom_range(0, 12));
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
